// File: rtl/lsu.sv
// Load/store stage between execute and writeback.
// It issues one word-aligned data-memory access per load or store.
// It aligns, masks and extends load data.
// Non-memory results pass through to writeback with one cycle of latency.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_receive_valid,
  output logic        lsu_receive_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] rsb,
  input  logic        ren,
  input  logic        wen,
  input  logic [7:0]  wmask,
  input  logic [31:0] rmask,
  input  logic        memory_read_signed,
  input  logic        reg_write_en_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] pc_in,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write_en,
  output logic [31:0] wb_pc,
  output logic        lsu_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        addr_q, rsb_q, rmask_q, data_q, pc_q;
  logic [3:0]         wmask_q;
  logic [4:0]         rd_q;
  logic               store_q, signed_q, rwe_q, err_q;

  logic               is_mem_c, misalign_c, timeout_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [31:0]        lane_c, load_c;
  logic               sign_c;
  logic               unused_c;

  assign unused_c = ^wmask[7:4];

  // Access legality: size encoding and natural alignment; stores take priority over loads
  always_comb begin
    is_mem_c   = ren | wen;
    misalign_c = 1'b0;
    if (wen) begin
      case (wmask[3:0])
        4'h1:    misalign_c = 1'b0;
        4'h3:    misalign_c = alu_result[0];
        4'hF:    misalign_c = |alu_result[1:0];
        default: misalign_c = 1'b1;
      endcase
    end else if (ren) begin
      case (rmask)
        32'h0000_00FF: misalign_c = 1'b0;
        32'h0000_FFFF: misalign_c = alu_result[0];
        32'hFFFF_FFFF: misalign_c = |alu_result[1:0];
        default:       misalign_c = 1'b1;
      endcase
    end
  end

  // Wait counter; the abort fires on the cycle the count would reach TIMEOUT
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign timeout_c = (cnt_inc_c == CNT_W'(TIMEOUT));

  // Load lane select, mask and optional sign extension
  always_comb begin
    lane_c = mem_rdata >> {addr_q[1:0], 3'b000};
    sign_c = 1'b0;
    if (rmask_q == 32'h0000_00FF)      sign_c = lane_c[7];
    else if (rmask_q == 32'h0000_FFFF) sign_c = lane_c[15];
    load_c = (lane_c & rmask_q) | ({32{signed_q & sign_c}} & ~rmask_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (lsu_receive_valid) state_d = (is_mem_c && !misalign_c) ? S_REQ : S_DONE;
      S_REQ:  if (mem_req_ready) state_d = S_WAIT;
      S_WAIT: if (mem_resp_valid || timeout_c) state_d = S_DONE;
      S_DONE: if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath capture: inputs on accept, load data or timeout error in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      rsb_q    <= '0;
      rmask_q  <= '0;
      wmask_q  <= '0;
      data_q   <= '0;
      pc_q     <= '0;
      rd_q     <= '0;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      rwe_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (lsu_receive_valid) begin
            addr_q   <= alu_result;
            rsb_q    <= rsb;
            rmask_q  <= rmask;
            wmask_q  <= wmask[3:0];
            data_q   <= alu_result;
            pc_q     <= pc_in;
            rd_q     <= rd_in;
            store_q  <= wen;
            signed_q <= memory_read_signed;
            rwe_q    <= reg_write_en_in;
            err_q    <= is_mem_c & misalign_c;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_inc_c;
          if (mem_resp_valid) begin
            if (!store_q) data_q <= load_c;
          end else if (timeout_c) begin
            err_q <= 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Output decode from the state and captured registers
  always_comb begin
    lsu_receive_ready = (state_q == S_IDLE);
    mem_req_valid     = (state_q == S_REQ);
    wb_valid          = (state_q == S_DONE);
    lsu_err           = (state_q == S_DONE) & err_q;
    mem_addr          = {addr_q[31:2], 2'b00};
    mem_wen           = store_q;
    mem_wdata         = rsb_q << {addr_q[1:0], 3'b000};
    mem_wmask         = 4'(wmask_q << addr_q[1:0]);
    wb_data           = data_q;
    wb_rd             = rd_q;
    wb_reg_write_en   = rwe_q & ~err_q;
    wb_pc             = pc_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store stage with hand-computed expectations.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_receive_valid, lsu_receive_ready;
  logic [31:0] alu_result, rsb, rmask, pc_in;
  logic        ren, wen, memory_read_signed, reg_write_en_in;
  logic [7:0]  wmask;
  logic [4:0]  rd_in;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        wb_valid, wb_ready, wb_reg_write_en, lsu_err;
  logic [31:0] wb_data, wb_pc;
  logic [4:0]  wb_rd;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .lsu_receive_valid(lsu_receive_valid), .lsu_receive_ready(lsu_receive_ready),
    .alu_result(alu_result), .rsb(rsb), .ren(ren), .wen(wen), .wmask(wmask),
    .rmask(rmask), .memory_read_signed(memory_read_signed),
    .reg_write_en_in(reg_write_en_in), .rd_in(rd_in), .pc_in(pc_in),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_reg_write_en(wb_reg_write_en), .wb_pc(wb_pc), .lsu_err(lsu_err)
  );

  // Count one comparison and report a mismatch
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    lsu_receive_valid = 0; alu_result = 0; rsb = 0; ren = 0; wen = 0; wmask = 0;
    rmask = 0; memory_read_signed = 0; reg_write_en_in = 0; rd_in = 0; pc_in = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; wb_ready = 0;
  endtask

  // Full load with ready memory and a response in the first WAIT cycle
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] rm,
                         input logic sgn, input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [31:0] exp);
    lsu_receive_valid = 1; alu_result = addr; ren = 1; rmask = rm; memory_read_signed = sgn;
    reg_write_en_in = 1; rd_in = 5'd7; pc_in = 32'h100; mem_req_ready = 1; wb_ready = 1;
    step();
    lsu_receive_valid = 0; ren = 0;
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_wen"}, 32'(mem_wen), 32'd0);
    step();
    mem_resp_valid = 1; mem_rdata = rdata;
    chk({tag, "_wait_nowb"}, 32'(wb_valid), 32'd0);
    step();
    mem_resp_valid = 0;
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_err"}, 32'(lsu_err), 32'd0);
    step();
    chk({tag, "_idle"}, 32'(lsu_receive_ready), 32'd1);
  endtask

  // Misaligned/illegal access: straight to DONE with an error, no memory request
  task automatic do_err(input string tag, input logic [31:0] addr, input logic r, input logic w,
                        input logic [7:0] wm, input logic [31:0] rm);
    lsu_receive_valid = 1; alu_result = addr; ren = r; wen = w; wmask = wm; rmask = rm;
    reg_write_en_in = 1; rd_in = 5'd9; wb_ready = 1;
    step();
    lsu_receive_valid = 0; ren = 0; wen = 0;
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, "_err"}, 32'(lsu_err), 32'd1);
    chk({tag, "_rwe"}, 32'(wb_reg_write_en), 32'd0);
    chk({tag, "_noreq"}, 32'(mem_req_valid), 32'd0);
    step();
  endtask

  int n;

  initial begin
    clr_in();
    rst = 1;
    step(); step();
    chk("rst_ready", 32'(lsu_receive_ready), 32'd1);
    chk("rst_req", 32'(mem_req_valid), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", 32'(lsu_err), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst = 0;
    step();

    // ALU pass-through
    lsu_receive_valid = 1; alu_result = 32'h1234; rd_in = 5'd5; reg_write_en_in = 1;
    pc_in = 32'h40; wb_ready = 1;
    step();
    lsu_receive_valid = 0;
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_rd", 32'(wb_rd), 32'd5);
    chk("alu_pc", wb_pc, 32'h40);
    chk("alu_rwe", 32'(wb_reg_write_en), 32'd1);
    chk("alu_noreq", 32'(mem_req_valid), 32'd0);
    chk("alu_not_ready", 32'(lsu_receive_ready), 32'd0);
    step();
    chk("alu_back_idle", 32'(wb_valid), 32'd0);
    chk("alu_ready", 32'(lsu_receive_ready), 32'd1);
    clr_in();

    // Load extraction
    do_load("ld_sb", 32'h8000_0003, 32'hFF, 1'b1, 32'h80AA_BBCC, 32'h8000_0000, 32'hFFFF_FF80);
    do_load("ld_uh", 32'h0000_0002, 32'hFFFF, 1'b0, 32'hBEEF_0000, 32'h0000_0000, 32'h0000_BEEF);
    do_load("ld_sh", 32'h0000_0010, 32'hFFFF, 1'b1, 32'h1234_8001, 32'h0000_0010, 32'hFFFF_8001);
    do_load("ld_ub", 32'h0000_0021, 32'hFF, 1'b0, 32'h80AA_BBCC, 32'h0000_0020, 32'h0000_00BB);
    do_load("ld_sw", 32'h0000_0004, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF, 32'h0000_0004, 32'hDEAD_BEEF);
    clr_in();

    // Store byte with request backpressure; ren also set, still a store
    lsu_receive_valid = 1; alu_result = 32'h101; wen = 1; ren = 1; wmask = 8'h01; rsb = 32'hAB;
    reg_write_en_in = 0; wb_ready = 1;
    step();
    lsu_receive_valid = 0; wen = 0; ren = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1;
      chk($sformatf("st_req_valid%0d", i), 32'(mem_req_valid), 32'd1);
      chk($sformatf("st_wmask%0d", i), 32'(mem_wmask), 32'h2);
      chk($sformatf("st_wdata%0d", i), mem_wdata, 32'h0000_AB00);
      chk($sformatf("st_addr%0d", i), mem_addr, 32'h100);
      chk($sformatf("st_wen%0d", i), 32'(mem_wen), 32'd1);
      step();
    end
    mem_req_ready = 0;
    chk("st_req_drop", 32'(mem_req_valid), 32'd0);
    mem_resp_valid = 1;
    step();
    mem_resp_valid = 0;
    chk("st_wb_valid", 32'(wb_valid), 32'd1);
    chk("st_data", wb_data, 32'h101);
    chk("st_rwe", 32'(wb_reg_write_en), 32'd0);
    chk("st_err", 32'(lsu_err), 32'd0);
    step();
    clr_in();

    // Illegal accesses
    do_err("bad_half_st", 32'h3, 1'b0, 1'b1, 8'h03, 32'h0);
    do_err("bad_rmask", 32'h0, 1'b1, 1'b0, 8'h00, 32'h0000_00F0);
    clr_in();

    // Misaligned word load, then writeback backpressure
    lsu_receive_valid = 1; alu_result = 32'h2; ren = 1; rmask = 32'hFFFF_FFFF;
    reg_write_en_in = 1; rd_in = 5'd3; pc_in = 32'h80; wb_ready = 0;
    step();
    lsu_receive_valid = 0; ren = 0;
    chk("mis_err", 32'(lsu_err), 32'd1);
    chk("mis_rwe", 32'(wb_reg_write_en), 32'd0);
    chk("mis_noreq", 32'(mem_req_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), 32'(wb_valid), 32'd1);
      chk($sformatf("bp_rd%0d", i), 32'(wb_rd), 32'd3);
      chk($sformatf("bp_pc%0d", i), wb_pc, 32'h80);
      chk($sformatf("bp_data%0d", i), wb_data, 32'h2);
      chk($sformatf("bp_not_ready%0d", i), 32'(lsu_receive_ready), 32'd0);
      step();
    end
    wb_ready = 1;
    step();
    chk("bp_release", 32'(wb_valid), 32'd0);
    clr_in();

    // Timeout: no response ever
    lsu_receive_valid = 1; alu_result = 32'h10; ren = 1; rmask = 32'hFF; reg_write_en_in = 1;
    mem_req_ready = 1; wb_ready = 0;
    step();
    lsu_receive_valid = 0; ren = 0;
    step();
    n = 0;
    while (!wb_valid && n < 400) begin
      n++;
      step();
    end
    chk("to_wait_cycles", 32'(n), 32'd255);
    chk("to_err", 32'(lsu_err), 32'd1);
    chk("to_rwe", 32'(wb_reg_write_en), 32'd0);
    wb_ready = 1;
    step();
    clr_in();

    // Response on the last WAIT cycle still succeeds
    lsu_receive_valid = 1; alu_result = 32'h20; ren = 1; rmask = 32'hFF; reg_write_en_in = 1;
    mem_req_ready = 1; wb_ready = 1;
    step();
    lsu_receive_valid = 0; ren = 0;
    step();
    for (int i = 0; i < 254; i++) step();
    chk("edge_still_wait", 32'(wb_valid), 32'd0);
    mem_resp_valid = 1; mem_rdata = 32'h1122_3344;
    step();
    mem_resp_valid = 0;
    chk("edge_wb_valid", 32'(wb_valid), 32'd1);
    chk("edge_err", 32'(lsu_err), 32'd0);
    chk("edge_data", wb_data, 32'h44);
    step();
    clr_in();

    // Reset while in WAIT; a late response is ignored
    lsu_receive_valid = 1; alu_result = 32'h30; ren = 1; rmask = 32'hFFFF_FFFF;
    mem_req_ready = 1; wb_ready = 1;
    step();
    lsu_receive_valid = 0; ren = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    chk("rstw_ready", 32'(lsu_receive_ready), 32'd1);
    chk("rstw_req", 32'(mem_req_valid), 32'd0);
    chk("rstw_wb", 32'(wb_valid), 32'd0);
    mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_resp_valid = 0;
    chk("late_resp_wb", 32'(wb_valid), 32'd0);
    chk("late_resp_ready", 32'(lsu_receive_ready), 32'd1);
    chk("late_resp_req", 32'(mem_req_valid), 32'd0);
    clr_in();

    // Reset while in REQ drops the request next cycle
    lsu_receive_valid = 1; alu_result = 32'h40; ren = 1; rmask = 32'hFFFF_FFFF;
    step();
    lsu_receive_valid = 0; ren = 0;
    chk("rstr_req_up", 32'(mem_req_valid), 32'd1);
    rst = 1;
    step();
    rst = 0;
    chk("rstr_req_down", 32'(mem_req_valid), 32'd0);
    chk("rstr_ready", 32'(lsu_receive_ready), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
